// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: one-outstanding-miss fill controller for the N-way icache.
// Issues the line-aligned L2 read, chooses a victim way, writes the returned
// line into the tag/data stores and hands the line back to fetch. It also
// turns L2 back-invalidates and a full flush sweep into tag-store writes.
module icache_fill_ctrl #(
   parameter int ADDR_SZ   = 32,
   parameter int SET_CNT   = 64,
   parameter int WAYS      = 4,
   parameter int LINE_BITS = 512,
   parameter int SET_W     = $clog2(SET_CNT),
   parameter int WAY_W     = $clog2(WAYS),
   parameter int OFF_W     = $clog2(LINE_BITS / 8),
   parameter int TAG_W     = ADDR_SZ - SET_W - OFF_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 miss_valid,
   input  logic [ADDR_SZ-1:0]   miss_addr,
   input  logic [WAYS-1:0]      miss_vld_vec,
   output logic                 miss_ready,
   output logic                 l2_req_valid,
   output logic [ADDR_SZ-1:0]   l2_req_addr,
   input  logic                 l2_req_ready,
   input  logic                 l2_rsp_valid,
   input  logic [LINE_BITS-1:0] l2_rsp_data,
   input  logic                 l2_rsp_err,
   input  logic                 inv_valid,
   input  logic [ADDR_SZ-1:0]   inv_addr,
   output logic                 inv_ready,
   input  logic                 flush_req,
   output logic                 flush_busy,
   output logic                 tag_wr_en,
   output logic [SET_W-1:0]     tag_wr_set,
   output logic [WAYS-1:0]      tag_wr_way,
   output logic [TAG_W-1:0]     tag_wr_tag,
   output logic                 tag_wr_vld,
   output logic                 tag_wr_match,
   output logic                 data_wr_en,
   output logic                 fill_done,
   output logic                 fill_err,
   output logic [LINE_BITS-1:0] fill_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_FILL  = 3'd3;
   localparam logic [2:0] S_INV   = 3'd4;
   localparam logic [2:0] S_FLUSH = 3'd5;

   // Clears the byte-offset bits so two addresses compare at line granularity.
   localparam logic [ADDR_SZ-1:0] LINE_MASK = {{(ADDR_SZ - OFF_W){1'b1}}, {OFF_W{1'b0}}};

   logic [2:0]           state;
   logic [ADDR_SZ-1:0]   pend_addr;
   logic [WAY_W-1:0]     victim;
   logic                 victim_from_rr;
   logic                 poison;
   logic                 rsp_err;
   logic [SET_W-1:0]     flush_idx;
   logic [WAY_W-1:0]     rr_ptr [SET_CNT];

   logic [SET_W-1:0]     miss_set;
   logic [SET_W-1:0]     pend_set;
   logic [TAG_W-1:0]     pend_tag;
   logic [SET_W-1:0]     inv_set;
   logic [TAG_W-1:0]     inv_tag;
   logic                 inv_hit;
   logic [WAY_W-1:0]     pick_way;
   logic                 pick_from_rr;
   logic                 fill_writes;

   assign miss_set = miss_addr[OFF_W +: SET_W];
   assign pend_set = pend_addr[OFF_W +: SET_W];
   assign pend_tag = pend_addr[ADDR_SZ-1 -: TAG_W];
   assign inv_set  = inv_addr[OFF_W +: SET_W];
   assign inv_tag  = inv_addr[ADDR_SZ-1 -: TAG_W];
   assign inv_hit  = ((inv_addr & LINE_MASK) == (pend_addr & LINE_MASK));
   assign fill_writes = !rsp_err && !poison;

   // Victim choice: lowest invalid way, else the set's round-robin pointer.
   always_comb begin
      pick_way     = rr_ptr[miss_set];
      pick_from_rr = 1'b1;
      for (int i = WAYS - 1; i >= 0; i--) begin
         pick_way     = miss_vld_vec[i] ? pick_way : WAY_W'(i);
         pick_from_rr = miss_vld_vec[i] ? pick_from_rr : 1'b0;
      end
   end

   // Controller state, pending-miss context, flush index and rr pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         pend_addr      <= {ADDR_SZ{1'b0}};
         victim         <= {WAY_W{1'b0}};
         victim_from_rr <= 1'b0;
         poison         <= 1'b0;
         rsp_err        <= 1'b0;
         flush_idx      <= {SET_W{1'b0}};
         fill_data      <= {LINE_BITS{1'b0}};
         for (int s = 0; s < SET_CNT; s++) rr_ptr[s] <= {WAY_W{1'b0}};
      end else begin
         case (state)
            S_IDLE: begin
               if (flush_req) begin
                  flush_idx <= {SET_W{1'b0}};
                  state     <= S_FLUSH;
               end else if (inv_valid) begin
                  state <= S_INV;
               end else if (miss_valid) begin
                  pend_addr      <= miss_addr;
                  victim         <= pick_way;
                  victim_from_rr <= pick_from_rr;
                  poison         <= 1'b0;
                  rsp_err        <= 1'b0;
                  state          <= S_REQ;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_REQ: begin
               if (l2_req_ready) state <= S_WAIT;
               else              state <= S_REQ;
            end
            S_WAIT: begin
               // An invalidate of the line in flight means the returned data is stale.
               if (inv_valid && inv_hit) poison <= 1'b1;
               else                      poison <= poison;
               if (l2_rsp_valid) begin
                  fill_data <= l2_rsp_data;
                  rsp_err   <= l2_rsp_err;
                  state     <= S_FILL;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_FILL: begin
               if (fill_writes && victim_from_rr) rr_ptr[pend_set] <= rr_ptr[pend_set] + WAY_W'(1);
               else                               rr_ptr[pend_set] <= rr_ptr[pend_set];
               poison <= 1'b0;
               state  <= S_IDLE;
            end
            S_INV: begin
               state <= S_IDLE;
            end
            S_FLUSH: begin
               flush_idx <= flush_idx + SET_W'(1);
               if (flush_idx == SET_W'(SET_CNT - 1)) begin
                  for (int s = 0; s < SET_CNT; s++) rr_ptr[s] <= {WAY_W{1'b0}};
                  state <= S_IDLE;
               end else begin
                  state <= S_FLUSH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Handshakes, status and the tag/data store write command for this cycle.
   always_comb begin
      miss_ready   = !rst && (state == S_IDLE) && !flush_req && !inv_valid;
      l2_req_valid = (state == S_REQ);
      l2_req_addr  = (state == S_REQ) ? (pend_addr & LINE_MASK) : {ADDR_SZ{1'b0}};
      inv_ready    = (state == S_INV) || ((state == S_WAIT) && inv_valid);
      flush_busy   = (state == S_FLUSH);
      fill_done    = (state == S_FILL);
      fill_err     = (state == S_FILL) && rsp_err;
      tag_wr_en    = 1'b0;
      tag_wr_set   = {SET_W{1'b0}};
      tag_wr_way   = {WAYS{1'b0}};
      tag_wr_tag   = {TAG_W{1'b0}};
      tag_wr_vld   = 1'b0;
      tag_wr_match = 1'b0;
      data_wr_en   = 1'b0;
      case (state)
         S_FILL: begin
            if (fill_writes) begin
               tag_wr_en  = 1'b1;
               data_wr_en = 1'b1;
               tag_wr_set = pend_set;
               tag_wr_way = WAYS'(1) << victim;
               tag_wr_tag = pend_tag;
               tag_wr_vld = 1'b1;
            end else begin
               tag_wr_en  = 1'b0;
            end
         end
         S_INV, S_WAIT: begin
            if (inv_ready) begin
               tag_wr_en    = 1'b1;
               tag_wr_match = 1'b1;
               tag_wr_set   = inv_set;
               tag_wr_way   = {WAYS{1'b1}};
               tag_wr_tag   = inv_tag;
            end else begin
               tag_wr_en    = 1'b0;
            end
         end
         S_FLUSH: begin
            tag_wr_en  = 1'b1;
            tag_wr_set = flush_idx;
            tag_wr_way = {WAYS{1'b1}};
         end
         default: tag_wr_en = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: randomized self-checking bench for icache_fill_ctrl.
// A transaction-level model tracks per-set round-robin pointers and the
// poison rule; every cycle of each miss, invalidate and flush is checked.
module tb_icache_fill_ctrl;
   localparam int ADDR_SZ = 32, SET_CNT = 64, WAYS = 4, LINE_BITS = 512;
   localparam int SET_W = 6, TAG_W = 20;

   logic                 clk, rst;
   logic                 miss_valid, miss_ready;
   logic [ADDR_SZ-1:0]   miss_addr;
   logic [WAYS-1:0]      miss_vld_vec;
   logic                 l2_req_valid, l2_req_ready;
   logic [ADDR_SZ-1:0]   l2_req_addr;
   logic                 l2_rsp_valid, l2_rsp_err;
   logic [LINE_BITS-1:0] l2_rsp_data;
   logic                 inv_valid, inv_ready;
   logic [ADDR_SZ-1:0]   inv_addr;
   logic                 flush_req, flush_busy;
   logic                 tag_wr_en, tag_wr_vld, tag_wr_match, data_wr_en;
   logic [SET_W-1:0]     tag_wr_set;
   logic [WAYS-1:0]      tag_wr_way;
   logic [TAG_W-1:0]     tag_wr_tag;
   logic                 fill_done, fill_err;
   logic [LINE_BITS-1:0] fill_data;

   int n_tests = 0;
   int n_fail  = 0;
   int rr_m [SET_CNT];

   icache_fill_ctrl dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_vld_vec(miss_vld_vec),
      .miss_ready(miss_ready),
      .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_ready(l2_req_ready),
      .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data), .l2_rsp_err(l2_rsp_err),
      .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_ready(inv_ready),
      .flush_req(flush_req), .flush_busy(flush_busy),
      .tag_wr_en(tag_wr_en), .tag_wr_set(tag_wr_set), .tag_wr_way(tag_wr_way),
      .tag_wr_tag(tag_wr_tag), .tag_wr_vld(tag_wr_vld), .tag_wr_match(tag_wr_match),
      .data_wr_en(data_wr_en), .fill_done(fill_done), .fill_err(fill_err),
      .fill_data(fill_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends even if the design stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [LINE_BITS-1:0] got,
                           input logic [LINE_BITS-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LINE_BITS-1:0] rand_line();
      logic [LINE_BITS-1:0] l;
      for (int i = 0; i < LINE_BITS / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic clear_model();
      for (int s = 0; s < SET_CNT; s++) rr_m[s] = 0;
   endtask

   task automatic idle_inputs();
      miss_valid = 1'b0; l2_req_ready = 1'b0; l2_rsp_valid = 1'b0; l2_rsp_err = 1'b0;
      inv_valid = 1'b0;
   endtask

   // inv_mode: 0 none, 1 pending line early in WAIT, 2 other line in WAIT,
   // 3 pending line in the same cycle as the response.
   task automatic do_miss(input logic [31:0] addr, input logic [3:0] vec, input bit err,
                          input int inv_mode, input int req_dly, input int rsp_dly,
                          input bit flush_in_wait);
      logic [31:0] line;
      logic [31:0] ia;
      logic [LINE_BITS-1:0] data;
      int set, vic;
      bit from_rr, poison, wr, inv, rsp;
      line = addr & 32'hFFFF_FFC0;
      set  = int'(addr[11:6]);
      vic  = -1;
      for (int i = 0; i < WAYS; i++) if (!vec[i] && vic < 0) vic = i;
      from_rr = (vic < 0);
      if (from_rr) vic = rr_m[set];
      poison = 1'b0;
      data = rand_line();

      miss_valid = 1'b1; miss_addr = addr; miss_vld_vec = vec;
      #1;
      check_eq("miss_ready_idle", miss_ready, 1);
      step();
      miss_valid = 1'b0; miss_addr = $urandom; miss_vld_vec = 4'($urandom);
      for (int r = 0; r <= req_dly; r++) begin
         l2_req_ready = (r == req_dly);
         #1;
         check_eq("l2_req_valid", l2_req_valid, 1);
         check_eq("l2_req_addr", l2_req_addr, line);
         check_eq("miss_ready_busy", miss_ready, 0);
         step();
      end
      l2_req_ready = 1'b0;
      if (flush_in_wait) flush_req = 1'b1;
      for (int w = 0; w <= rsp_dly; w++) begin
         rsp = (w == rsp_dly);
         inv = ((inv_mode == 1 || inv_mode == 2) && w == 0) || (inv_mode == 3 && rsp);
         ia  = (inv_mode == 2) ? (addr ^ 32'h0000_1000) : (line | 32'($urandom_range(0, 63)));
         inv_valid = inv; inv_addr = ia;
         l2_rsp_valid = rsp; l2_rsp_data = data; l2_rsp_err = err;
         #1;
         check_eq("wait_inv_ready", inv_ready, inv);
         check_eq("wait_tag_wr_en", tag_wr_en, inv);
         check_eq("wait_fill_done", fill_done, 0);
         if (inv) begin
            check_eq("wait_inv_cmd", {tag_wr_match, tag_wr_vld, tag_wr_way, tag_wr_set, tag_wr_tag},
                     {1'b1, 1'b0, 4'hF, ia[11:6], ia[31:12]});
            if (inv_mode != 2) poison = 1'b1;
         end
         step();
      end
      l2_rsp_valid = 1'b0; l2_rsp_err = 1'b0;
      inv_valid = 1'b1; inv_addr = $urandom;
      #1;
      wr = !err && !poison;
      check_eq("fill_done", fill_done, 1);
      check_eq("fill_err", fill_err, err);
      check_eq("fill_data", fill_data, data);
      check_eq("fill_tag_wr_en", tag_wr_en, wr);
      check_eq("fill_data_wr_en", data_wr_en, wr);
      check_eq("fill_inv_stall", inv_ready, 0);
      if (wr) begin
         check_eq("fill_cmd", {tag_wr_match, tag_wr_vld, tag_wr_way, tag_wr_set, tag_wr_tag},
                  {1'b0, 1'b1, 4'(1 << vic), addr[11:6], addr[31:12]});
         if (from_rr) rr_m[set] = (rr_m[set] + 1) % WAYS;
      end
      step();
      inv_valid = 1'b0;
      #1;
      check_eq("post_fill_done", fill_done, 0);
      check_eq("post_miss_ready", miss_ready, !flush_req);
   endtask

   // Expects flush_req already high with the controller idle.
   task automatic flush_sweep(input bit hold_inv);
      logic [31:0] ia;
      int k;
      ia = $urandom;
      inv_valid = hold_inv; inv_addr = ia;
      miss_valid = 1'b1; miss_addr = $urandom;
      #1;
      check_eq("flush_miss_blocked", miss_ready, 0);
      k = 0;
      while (!flush_busy && k < 4) begin
         step();
         k++;
      end
      check_eq("flush_started", flush_busy, 1);
      flush_req = 1'b0; miss_valid = 1'b0;
      for (int i = 0; i < SET_CNT; i++) begin
         #1;
         check_eq("flush_cmd", {flush_busy, tag_wr_en, tag_wr_match, tag_wr_vld, tag_wr_way,
                                tag_wr_set, data_wr_en, inv_ready},
                  {1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 6'(i), 1'b0, 1'b0});
         step();
      end
      clear_model();
      #1;
      check_eq("flush_end", flush_busy, 0);
      if (hold_inv) begin
         check_eq("flush_inv_held", {inv_ready, l2_req_valid}, 2'b00);
         step();
         check_eq("inv_after_flush", {inv_ready, tag_wr_en, tag_wr_match, tag_wr_set},
                  {1'b1, 1'b1, 1'b1, ia[11:6]});
         inv_valid = 1'b0;
         step();
      end
   endtask

   // Back-invalidate while idle; a simultaneous miss must lose to it.
   task automatic inv_idle(input logic [31:0] ia);
      inv_valid = 1'b1; inv_addr = ia;
      miss_valid = 1'b1; miss_addr = $urandom; miss_vld_vec = 4'h0;
      #1;
      check_eq("inv_idle_miss_ready", miss_ready, 0);
      check_eq("inv_idle_no_ready", inv_ready, 0);
      step();
      miss_valid = 1'b0;
      #1;
      check_eq("inv_cmd", {inv_ready, l2_req_valid, tag_wr_en, tag_wr_match, tag_wr_vld,
                           tag_wr_way, tag_wr_set, tag_wr_tag, data_wr_en},
               {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, ia[11:6], ia[31:12], 1'b0});
      inv_valid = 1'b0;
      step();
   endtask

   initial begin
      logic [31:0] a;
      int sets [4] = '{3, 5, 8, 63};
      int act;
      rst = 1'b1; flush_req = 1'b0; inv_addr = '0; miss_addr = '0; miss_vld_vec = '0;
      l2_rsp_data = '0;
      idle_inputs();
      clear_model();
      step(); step();
      check_eq("reset_outputs", {miss_ready, l2_req_valid, inv_ready, flush_busy, tag_wr_en,
                                 data_wr_en, fill_done, fill_err, l2_req_addr}, '0);
      check_eq("reset_fill_data", fill_data, '0);
      rst = 1'b0;
      step();
      check_eq("ready_after_reset", miss_ready, 1);

      // Cold miss: line 0x1200, set 8, way 0.
      do_miss(32'h0000_1234, 4'b0000, 1'b0, 0, 0, 0, 1'b0);
      // Five misses to a full set 3 walk the round-robin pointer 0,1,2,3,0.
      for (int k = 0; k < 5; k++) do_miss({20'(k + 16), 6'd3, 6'd4}, 4'hF, 1'b0, 0, 0, 0, 1'b0);
      // Invalidate of the pending line during WAIT poisons the fill.
      do_miss(32'h0004_50C0, 4'hF, 1'b0, 1, 1, 2, 1'b0);
      // Error response: no writes, pointer untouched.
      do_miss(32'h0005_50C0, 4'hF, 1'b1, 0, 2, 1, 1'b0);
      do_miss(32'h0006_50C0, 4'hF, 1'b0, 0, 0, 0, 1'b0);
      // Flush requested while waiting: fill completes first, then the sweep.
      do_miss(32'h0007_0200, 4'b0111, 1'b0, 0, 0, 3, 1'b1);
      flush_sweep(1'b0);
      do_miss(32'h0008_00C0, 4'hF, 1'b0, 0, 0, 0, 1'b0);

      // Randomized mix of misses, idle invalidates and flushes.
      for (int n = 0; n < 60; n++) begin
         act = $urandom_range(0, 19);
         a = {20'($urandom), 6'(sets[$urandom_range(0, 3)]), 6'($urandom)};
         if (act < 16)
            do_miss(a, ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
         else if (act < 19)
            inv_idle(a);
         else begin
            flush_req = 1'b1;
            flush_sweep(1'b1);
         end
      end

      // Reset while waiting on L2 drops the fill completely.
      miss_valid = 1'b1; miss_addr = 32'h0009_0100; miss_vld_vec = 4'h0;
      step();
      miss_valid = 1'b0; l2_req_ready = 1'b1;
      step();
      l2_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("rst_mid_fill", {miss_ready, l2_req_valid, inv_ready, tag_wr_en, data_wr_en,
                                fill_done, fill_err, flush_busy}, '0);
      l2_rsp_valid = 1'b1; l2_rsp_data = rand_line();
      step();
      check_eq("rst_no_fill", {fill_done, tag_wr_en, data_wr_en}, '0);
      rst = 1'b0; l2_rsp_valid = 1'b0;
      clear_model();
      step();
      check_eq("rst_release_ready", miss_ready, 1);
      check_eq("rst_release_nofill", fill_done, 0);
      // Pointers restart at way 0 after reset.
      do_miss(32'h000A_00C0, 4'hF, 1'b0, 0, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
